// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM external memory port arbiter:
// state encoding, default bus widths and the full byte-select constant.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_BUS = 32;
  localparam int unsigned DATA_BUS = 32;
  localparam int unsigned SEL_W    = 4;

  localparam logic [SEL_W-1:0] SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_BUSY  = 2'd1,
    ST_MEM_BUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_timeout_counter.sv
// Busy-cycle watchdog for the memory arbiter; used only when ARB_TIMEOUT_EN is defined.
// o_expired is asserted during the BUSY cycle whose increment would reach TIMEOUT.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single external memory port between IF fetches and MEM loads/stores.
// MEM has fixed priority; optional watchdog abort is enabled with the ARB_TIMEOUT_EN macro.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_BUS,
  parameter int unsigned DATA_WIDTH = DATA_BUS,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_ready,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  output logic                  o_if_err,
  input  logic                  i_mem_req,
  input  logic                  i_mem_we,
  input  logic [SEL_W-1:0]      i_mem_sel,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_wdata,
  output logic                  o_mem_ready,
  output logic [DATA_WIDTH-1:0] o_mem_rdata,
  output logic                  o_mem_err,
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [SEL_W-1:0]      o_bus_sel,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  input  logic                  i_bus_ack,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata,
  output logic                  o_stall_req
);

  arb_state_e            r_state, w_state_nxt;
  logic                  r_bus_req, w_bus_req_nxt;
  logic                  r_bus_we, w_bus_we_nxt;
  logic [SEL_W-1:0]      r_bus_sel, w_bus_sel_nxt;
  logic [ADDR_WIDTH-1:0] r_bus_addr, w_bus_addr_nxt;
  logic [DATA_WIDTH-1:0] r_bus_wdata, w_bus_wdata_nxt;
  logic                  r_if_ready, w_if_ready_nxt;
  logic                  r_mem_ready, w_mem_ready_nxt;
  logic                  r_if_err, w_if_err_nxt;
  logic                  r_mem_err, w_mem_err_nxt;
  logic [DATA_WIDTH-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [DATA_WIDTH-1:0] r_mem_rdata, w_mem_rdata_nxt;

  logic w_grant;
  logic w_busy;
  logic w_expired;
  logic w_if_req_eff;
  logic w_mem_req_eff;

  assign w_busy = (r_state != ST_IDLE);

  // A requester whose ready is high is still presenting its finished request.
  assign w_if_req_eff  = i_if_req  & ~r_if_ready;
  assign w_mem_req_eff = i_mem_req & ~r_mem_ready;

`ifdef ARB_TIMEOUT_EN
  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_grant),
    .i_enable  (w_busy & ~i_bus_ack),
    .o_expired (w_expired)
  );
`else
  logic w_unused;
  assign w_unused  = ^{32'(TIMEOUT)};
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_if_err    <= 1'b0;
      r_mem_err   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_sel   <= w_bus_sel_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_mem_ready <= w_mem_ready_nxt;
      r_if_err    <= w_if_err_nxt;
      r_mem_err   <= w_mem_err_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bus_req_nxt   = r_bus_req;
    w_bus_we_nxt    = r_bus_we;
    w_bus_sel_nxt   = r_bus_sel;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wdata_nxt = r_bus_wdata;
    w_if_ready_nxt  = 1'b0;
    w_mem_ready_nxt = 1'b0;
    w_if_err_nxt    = 1'b0;
    w_mem_err_nxt   = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_mem_rdata_nxt = r_mem_rdata;
    w_grant         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_mem_req_eff) begin
          w_grant         = 1'b1;
          w_bus_req_nxt   = 1'b1;
          w_bus_we_nxt    = i_mem_we;
          w_bus_sel_nxt   = i_mem_sel;
          w_bus_addr_nxt  = i_mem_addr;
          w_bus_wdata_nxt = i_mem_wdata;
          w_state_nxt     = ST_MEM_BUSY;
        end else if (w_if_req_eff) begin
          w_grant         = 1'b1;
          w_bus_req_nxt   = 1'b1;
          w_bus_we_nxt    = 1'b0;
          w_bus_sel_nxt   = SEL_ALL;
          w_bus_addr_nxt  = i_if_addr;
          w_bus_wdata_nxt = '0;
          w_state_nxt     = ST_IF_BUSY;
        end
      end
      ST_IF_BUSY: begin
        if (i_bus_ack) begin
          w_if_rdata_nxt = i_bus_rdata;
          w_if_ready_nxt = 1'b1;
          w_bus_req_nxt  = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else if (w_expired) begin
          w_if_rdata_nxt = '0;
          w_if_ready_nxt = 1'b1;
          w_if_err_nxt   = 1'b1;
          w_bus_req_nxt  = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_MEM_BUSY: begin
        // Stores leave the last load data in place.
        if (i_bus_ack) begin
          if (!r_bus_we) begin
            w_mem_rdata_nxt = i_bus_rdata;
          end
          w_mem_ready_nxt = 1'b1;
          w_bus_req_nxt   = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else if (w_expired) begin
          w_mem_rdata_nxt = '0;
          w_mem_ready_nxt = 1'b1;
          w_mem_err_nxt   = 1'b1;
          w_bus_req_nxt   = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_bus_req_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_sel   = r_bus_sel;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_if_ready  = r_if_ready;
  assign o_mem_ready = r_mem_ready;
  assign o_if_err    = r_if_err;
  assign o_mem_err   = r_mem_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_mem_rdata = r_mem_rdata;

  assign o_stall_req = (i_if_req & ~r_if_ready) | (i_mem_req & ~r_mem_ready);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the CPU's single external memory port between instruction fetch (IF stage, PC-driven) and data access (MEM stage load/store). It grants one transaction at a time, holds the bus request stable until the memory acknowledges, returns read data to the granted requester and raises a pipeline stall while any request is outstanding. The MEM stage has fixed priority over IF because it holds the older instruction.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- TIMEOUT, 255, max cycles waiting for bus_ack (used only with ARB_TIMEOUT_EN)

- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  ADDR_WIDTH  fetch address
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched instruction word (registered)
- if_err  out  1  one-cycle pulse with if_ready on timeout abort
- mem_req  in  1  data request; held with payload until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_sel  in  4  byte enables
- mem_addr  in  ADDR_WIDTH  data address
- mem_wdata  in  DATA_WIDTH  store data
- mem_ready  out  1  one-cycle pulse: data access complete
- mem_rdata  out  DATA_WIDTH  load data (registered)
- mem_err  out  1  one-cycle pulse with mem_ready on timeout abort
- bus_req  out  1  external transaction active
- bus_we, bus_sel, bus_addr, bus_wdata  out  1/4/ADDR_WIDTH/DATA_WIDTH  registered transaction payload
- bus_ack  in  1  memory completion strobe
- bus_rdata  in  DATA_WIDTH  memory read data, valid with bus_ack
- stall_req  out  1  to pipeline controller: a request is pending

## Operation
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
- IDLE: mem_req sampled high -> latch MEM payload into bus_* registers, bus_req=1, go MEM_BUSY; else if_req high -> latch if_addr, bus_we=0, bus_sel=4'hF, bus_wdata=0, go IF_BUSY; else stay.
- Requester masking: in the cycle a requester's ready is high, its req is the completing request and is ignored by arbitration.
- BUSY: bus_* held stable. On bus_ack: capture bus_rdata into granted requester's rdata (loads/fetches only; on store mem_rdata retains old value), pulse that ready, bus_req=0, go IDLE.
- bus_ack in IDLE is ignored.
- stall_req = (if_req & ~if_ready) | (mem_req & ~mem_ready), combinational.
- Reset values: state IDLE; bus_req, bus_we, if_ready, mem_ready, if_err, mem_err = 0; bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata = 0.
- rst mid-transaction: next posedge drops bus_req, returns to IDLE, no ready pulse; late bus_ack is ignored.

## Timing
- req sampled at edge N -> bus_req high after edge N.
- bus_ack sampled at edge M -> ready/rdata valid after edge M; bus_req low after edge M.
- Minimum latency: 2 cycles from req to ready (ack in first BUSY cycle).
- One IDLE cycle minimum between transactions; new grant sampled at edge M+1.
- Simultaneous if_req and mem_req in IDLE: MEM wins; IF granted next IDLE.

## Configuration
- ARB_TIMEOUT_EN defined: cycle counter (width clog2(TIMEOUT+1)) clears on grant, increments each BUSY cycle without bus_ack; reaching TIMEOUT aborts: bus_req=0, granted ready and err pulse together, rdata forced to 0, go IDLE. bus_ack on the same cycle as timeout wins (normal completion).
- Not defined: no counter; BUSY waits indefinitely; if_err, mem_err tied 0. Ports exist in both builds.

## Structure
- Shared definitions file: state encodings, ADDR_BUS/DATA_BUS widths, byte-select all-ones constant.
- One sub-module: arb_timeout_counter (clk, rst, clear, enable, expired), instantiated only under ARB_TIMEOUT_EN.

## Test plan
- Single fetch: if_req=1, if_addr=32'h0000_0004, ack after 3 cycles with bus_rdata=32'h2402_0001 -> bus_addr=32'h4, bus_we=0; if_ready pulses one cycle, if_rdata=32'h2402_0001.
- Collision: if_req and mem_req (load, addr 32'h1000) same cycle -> MEM granted first; IF granted in IDLE cycle after mem_ready; stall_req high throughout both.
- Store: mem_we=1, mem_sel=4'b0011, wdata=32'hDEAD_BEEF -> bus payload matches, mem_ready pulses, mem_rdata unchanged.
- Reset mid-MEM_BUSY: rst at cycle 2 of transaction -> bus_req 0 next cycle, no mem_ready; later bus_ack produces no ready.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): no bus_ack -> after 4 BUSY cycles if_ready and if_err pulse, if_rdata=0; without macro bus_req stays high indefinitely.
- Stray bus_ack in IDLE -> no ready pulses, state unchanged.
